// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR word arbiter: state width, feedback taps,
// default seed, FSM state encoding and the single permitted LFSR step function.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int CNT_W  = 8;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // Feedback taps at bits 10, 8, 3 and 1.
  localparam lfsr_t LFSR_TAPS         = 16'h050A;
  localparam lfsr_t LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_READY   = 2'd1,
    ST_ADVANCE = 2'd2
  } fsm_state_t;

  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 16-bit Fibonacci LFSR register. A load takes priority over a step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter lfsr_t RESET_VAL = LFSR_DEFAULT_SEED
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  lfsr_t load_val,
  input  logic  step,
  output lfsr_t s
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= RESET_VAL;
    end else if (load) begin
      s <= load_val;
    end else if (step) begin
      s <= lfsr_next(s);
    end
  end

endmodule

// File: rtl/lfsr_req_arbiter.sv
// Shares one LFSR among NUM_REQ consumers: warm-up after reset/seed, round-robin
// one-word-per-grant issue, STEPS advances between words, and zero-state recovery.
module lfsr_req_arbiter
  import lfsr_pkg::*;
#(
  parameter int    NUM_REQ      = 4,
  parameter int    STEPS        = 16,
  parameter int    WARMUP       = 32,
  parameter lfsr_t DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_valid,
  input  lfsr_t              seed,
  output logic               seed_ready,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output lfsr_t              rnd_data,
  output logic               busy,
  output logic               lockup_evt,
  output fsm_state_t         fsm_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1.
  // Ready is only raised in READY with a non-zero LFSR state; a seed offer wins
  // over requests, and requesters sample rnd_data in their grant cycle.

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             evt_q, evt_d;

  logic             load, step;
  lfsr_t            load_val;
  lfsr_t            s;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [PTR_W-1:0]   grant_nxt;

  lfsr_core #(.RESET_VAL(DEFAULT_SEED)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .s        (s)
  );

  // Round-robin search starting at ptr_q, wrapping at NUM_REQ.
  always_comb begin
    int               idx_i;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    found     = 1'b0;
    grant_nxt = '0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_i = int'(ptr_q) + k;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      idx = PTR_W'(idx_i);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_nxt  = (idx_i == NUM_REQ - 1) ? '0 : PTR_W'(idx_i + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    evt_d      = 1'b0;
    load       = 1'b0;
    load_val   = DEFAULT_SEED;
    step       = 1'b0;
    req_ready  = '0;
    seed_ready = 1'b0;

    if (s == '0) begin
      // Lock-up recovery overrides everything, including handshakes.
      load    = 1'b1;
      evt_d   = 1'b1;
      cnt_d   = CNT_W'(WARMUP);
      state_d = ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_READY;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_READY: begin
          seed_ready = 1'b1;
          if (seed_valid) begin
            load     = 1'b1;
            load_val = (seed == '0) ? DEFAULT_SEED : seed;
            evt_d    = (seed == '0);
            cnt_d    = CNT_W'(WARMUP);
            state_d  = ST_WARMUP;
          end else if (found) begin
            req_ready = grant;
            ptr_d     = grant_nxt;
            cnt_d     = CNT_W'(STEPS);
            state_d   = ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_READY;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          cnt_d   = CNT_W'(WARMUP);
          state_d = ST_WARMUP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WARMUP;
      cnt_q   <= CNT_W'(WARMUP);
      ptr_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      evt_q   <= evt_d;
    end
  end

  assign rnd_data   = s;
  assign busy       = (state_q != ST_READY);
  assign lockup_evt = evt_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// Bench for lfsr_req_arbiter: a cycle table on a WARMUP=1/STEPS=1 instance plus
// reset-abort and counter-length sequences on a 3-requester WARMUP=4/STEPS=5 instance.
module tb_lfsr_req_arbiter;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       seed_valid;
  logic [15:0] seed;
  logic       seed_ready;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [15:0] rnd_data;
  logic       busy;
  logic       lockup_evt;
  fsm_state_t fsm_state;

  logic       seed_valid2;
  logic [15:0] seed2;
  logic       seed_ready2;
  logic [2:0] req_valid2;
  logic [2:0] req_ready2;
  logic [15:0] rnd_data2;
  logic       busy2;
  logic       lockup_evt2;
  fsm_state_t fsm_state2;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  lfsr_req_arbiter #(.NUM_REQ(4), .STEPS(1), .WARMUP(1)) u_dut (
    .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(seed_ready), .req_valid(req_valid), .req_ready(req_ready),
    .rnd_data(rnd_data), .busy(busy), .lockup_evt(lockup_evt), .fsm_state(fsm_state)
  );

  lfsr_req_arbiter #(.NUM_REQ(3), .STEPS(5), .WARMUP(4)) u_dut2 (
    .clk(clk), .reset(reset), .seed_valid(seed_valid2), .seed(seed2),
    .seed_ready(seed_ready2), .req_valid(req_valid2), .req_ready(req_ready2),
    .rnd_data(rnd_data2), .busy(busy2), .lockup_evt(lockup_evt2), .fsm_state(fsm_state2)
  );

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic [3:0]  rv;
    logic [3:0]  rr;
    logic        sr;
    logic        bz;
    logic [15:0] rnd;
    logic        evt;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic sv, input logic [15:0] sd, input logic [3:0] rv,
                              input logic [3:0] rr, input logic sr, input logic bz,
                              input logic [15:0] rnd, input logic evt);
    vec_t v;
    v.sv = sv; v.sd = sd; v.rv = rv; v.rr = rr;
    v.sr = sr; v.bz = bz; v.rnd = rnd; v.evt = evt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for the next non-zero req_ready2; n counts cycles from the previous grant.
  task automatic wait_grant2(output int n);
    n = 1;
    @(negedge clk);
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready2 != 3'b000) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    seed_valid = 1'b0; seed = '0; req_valid = '0;
    seed_valid2 = 1'b0; seed2 = '0; req_valid2 = '0;

    //              sv    seed      rv       rr      sr    busy  rnd       evt
    vecs[0]  = mk(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'hACE1, 1'b0);
    vecs[1]  = mk(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h59C3, 1'b0);
    vecs[2]  = mk(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h59C3, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0000, 4'b0001, 4'b0001, 1'b1, 1'b0, 16'h59C3, 1'b0);
    vecs[4]  = mk(1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 16'h59C3, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0000, 4'b0001, 4'b0001, 1'b1, 1'b0, 16'hB386, 1'b0);
    vecs[6]  = mk(1'b0, 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'hB386, 1'b0);
    vecs[7]  = mk(1'b0, 16'h0000, 4'b1111, 4'b0010, 1'b1, 1'b0, 16'h670C, 1'b0);
    vecs[8]  = mk(1'b0, 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'h670C, 1'b0);
    vecs[9]  = mk(1'b0, 16'h0000, 4'b1111, 4'b0100, 1'b1, 1'b0, 16'hCE19, 1'b0);
    vecs[10] = mk(1'b0, 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'hCE19, 1'b0);
    vecs[11] = mk(1'b0, 16'h0000, 4'b1111, 4'b1000, 1'b1, 1'b0, 16'h9C32, 1'b0);
    vecs[12] = mk(1'b0, 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'h9C32, 1'b0);
    vecs[13] = mk(1'b0, 16'h0000, 4'b1111, 4'b0001, 1'b1, 1'b0, 16'h3864, 1'b0);
    vecs[14] = mk(1'b0, 16'h0000, 4'b1010, 4'b0000, 1'b0, 1'b1, 16'h3864, 1'b0);
    vecs[15] = mk(1'b0, 16'h0000, 4'b1010, 4'b0010, 1'b1, 1'b0, 16'h70C8, 1'b0);
    vecs[16] = mk(1'b0, 16'h0000, 4'b1010, 4'b0000, 1'b0, 1'b1, 16'h70C8, 1'b0);
    vecs[17] = mk(1'b0, 16'h0000, 4'b1010, 4'b1000, 1'b1, 1'b0, 16'hE191, 1'b0);
    vecs[18] = mk(1'b0, 16'h0000, 4'b1010, 4'b0000, 1'b0, 1'b1, 16'hE191, 1'b0);
    vecs[19] = mk(1'b0, 16'h0000, 4'b1010, 4'b0010, 1'b1, 1'b0, 16'hC323, 1'b0);
    vecs[20] = mk(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'hC323, 1'b0);
    vecs[21] = mk(1'b1, 16'h1234, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h8646, 1'b0);
    vecs[22] = mk(1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 16'h1234, 1'b0);
    vecs[23] = mk(1'b0, 16'h0000, 4'b0001, 4'b0001, 1'b1, 1'b0, 16'h2468, 1'b0);
    vecs[24] = mk(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h2468, 1'b0);
    vecs[25] = mk(1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h48D0, 1'b0);
    vecs[26] = mk(1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 16'hACE1, 1'b1);
    vecs[27] = mk(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h59C3, 1'b0);
    vecs[28] = mk(1'b1, 16'h8000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h59C3, 1'b0);
    vecs[29] = mk(1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 16'h8000, 1'b0);
    vecs[30] = mk(1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[31] = mk(1'b0, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 16'hACE1, 1'b1);
    vecs[32] = mk(1'b0, 16'h0000, 4'b0001, 4'b0001, 1'b1, 1'b0, 16'h59C3, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_seed_ready", 32'(seed_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_rnd", 32'(rnd_data), 32'hACE1);
    check("rst_evt", 32'(lockup_evt), 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_WARMUP));

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin
      seed_valid = vecs[i].sv;
      seed       = vecs[i].sd;
      req_valid  = vecs[i].rv;
      #1;
      check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].rr));
      check($sformatf("v%0d_seed_ready", i), 32'(seed_ready), 32'(vecs[i].sr));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
      check($sformatf("v%0d_rnd", i), 32'(rnd_data), 32'(vecs[i].rnd));
      check($sformatf("v%0d_evt", i), 32'(lockup_evt), 32'(vecs[i].evt));
      @(negedge clk);
    end

    // Reset asserted in ADVANCE (pointer is 1 here) must restore reset outputs at once.
    seed_valid = 1'b0;
    req_valid  = 4'b1111;
    #1;
    check("adv_busy", 32'(busy), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'h0);
    check("abort_seed_ready", 32'(seed_ready), 32'h0);
    check("abort_busy", 32'(busy), 32'h1);
    check("abort_rnd", 32'(rnd_data), 32'hACE1);
    check("abort_evt", 32'(lockup_evt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rewarm_req_ready", 32'(req_ready), 32'h0);
    check("rewarm_busy", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h1);
    check("post_rst_rnd", 32'(rnd_data), 32'h59C3);

    // Multi-cycle counters on the WARMUP=4, STEPS=5, 3-requester instance.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (!busy2) break;
      n++;
      @(negedge clk);
    end
    check("warmup_len", 32'(n), 32'd4);
    check("warmup_rnd", 32'(rnd_data2), 32'hCE19);
    req_valid2 = 3'b111;
    #1;
    check("g0_ready", 32'(req_ready2), 32'h1);
    wait_grant2(n);
    check("g1_spacing", 32'(n), 32'd6);
    check("g1_ready", 32'(req_ready2), 32'h2);
    check("g1_rnd", 32'(rnd_data2), 32'hC323);
    wait_grant2(n);
    check("g2_spacing", 32'(n), 32'd6);
    check("g2_ready", 32'(req_ready2), 32'h4);
    wait_grant2(n);
    check("g3_wrap_ready", 32'(req_ready2), 32'h1);
    req_valid2 = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_req_arbiter.md
Name: lfsr_req_arbiter

Overview:
Owns a 16-bit Fibonacci LFSR and shares its output among NUM_REQ consumers over a valid/ready handshake. After a seed load or reset it runs a warm-up sequence. It then issues one word per grant, advancing the LFSR STEPS times between words to decorrelate them. It detects the all-zero lock-up state and recovers from it. It sits between the random-stimulus consumers and the LFSR datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
STEPS, 16, LFSR advances between issued words (1..255)
WARMUP, 32, LFSR advances after reset or seed load before the first grant (1..255)
DEFAULT_SEED, 16'hACE1, reset and lock-up recovery value; must be non-zero

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
seed_valid  in  1  new seed offered
seed  in  16  seed value
seed_ready  out  1  seed accepted this cycle when seed_valid is also 1
req_valid  in  NUM_REQ  per-requester word request
req_ready  out  NUM_REQ  one-hot grant; the word transfers when req_valid[i] and req_ready[i] are both 1
rnd_data  out  16  current LFSR state, shared by all requesters
busy  out  1  1 in WARMUP/ADVANCE
lockup_evt  out  1  one-cycle pulse on lock-up recovery or zero-seed substitution

Behaviour:
- LFSR step: s <= {s[14:0], s[10]^s[8]^s[3]^s[1]}; no other update form exists.
- Reset (reset==0, async): s=DEFAULT_SEED, fsm=WARMUP, cnt=WARMUP, rr_ptr=0. Outputs: req_ready=0, seed_ready=0, busy=1, lockup_evt=0. Reset mid-operation aborts any pending warm-up or advance.
- FSM states: WARMUP, READY, ADVANCE.
- WARMUP: step every cycle, decrement cnt; at cnt==1 step and go to READY. Exactly WARMUP steps occur.
- READY: busy=0; s is held; seed_ready=1.
  - Seed handshake: if seed_valid, load s<=seed (seed==0 loads DEFAULT_SEED and pulses lockup_evt), set cnt=WARMUP, go to WARMUP. req_ready is all 0 that cycle; seed has priority over requests.
  - Otherwise req_ready is one-hot to the first asserted req_valid bit, searching from rr_ptr upward with wrap. Grant is combinational from req_valid.
  - On grant to i: rr_ptr <= (i+1) mod NUM_REQ, cnt=STEPS, go to ADVANCE. The requester samples rnd_data in the grant cycle.
  - No req_valid: stay in READY, no step.
- ADVANCE: step every cycle for exactly STEPS cycles, then go to READY. Minimum spacing between grants is STEPS+1 cycles.
- req_ready and seed_ready are 0 outside READY.
- Lock-up: if s==0 in any state, next cycle s<=DEFAULT_SEED, lockup_evt=1 for one cycle, cnt=WARMUP, fsm=WARMUP. This overrides any handshake in that cycle; req_ready and seed_ready are 0 while s==0.
- Requesters may hold or drop req_valid freely; an ungranted request has no effect.
- rnd_data always equals s.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=16
  - tap constant (bits 10, 8, 3, 1)
  - lfsr_t typedef
  - fsm state enum {WARMUP, READY, ADVANCE}
  - LFSR_DEFAULT_SEED
- Sub-module lfsr_core: holds s; inputs load, load_val, step; output s. Load has priority over step.
- Arbiter, counter and FSM live in lfsr_req_arbiter.

Test Plan:
- WARMUP=1, reset release, hold all req_valid=0 -> after 1 cycle busy=0 and rnd_data=16'h59C3 (one step from 16'hACE1); the value stays constant while idle.
- WARMUP=1, STEPS=1, req_valid=4'b0001 held -> grant sees rnd_data=16'h59C3; next grant sees 16'hB386; grants are 2 cycles apart.
- req_valid=4'b1111 held -> grants rotate 0,1,2,3,0 one-hot; with req_valid=4'b1010 after a grant to 1, the next grant goes to 3, then 1.
- In READY, seed_valid=1 with seed=16'h1234 and req_valid=4'b0001 in the same cycle -> seed_ready=1, req_ready=0, busy=1 for WARMUP cycles; the first word is 16'h1234 stepped WARMUP times.
- Seed 16'h0000 -> lockup_evt pulses 1 cycle, s=16'hACE1, warm-up repeats; no grant during it.
- Assert reset during ADVANCE -> outputs return to reset values immediately, rr_ptr=0, full WARMUP runs before the next grant.
